// File: rtl/sr_seq_pkg.sv
// Shared types and helpers for the SR latch write sequencer.
// Holds the FSM state enum, op encodings and the counter-width helper.
package sr_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    VERIFY,
    DONE
  } seq_state_t;

  localparam logic OP_SET = 1'b1;
  localparam logic OP_CLR = 1'b0;

  function automatic int cnt_w(
    input int setup_cyc,
    input int pulse_cyc
  );
    int m;
    m = (setup_cyc > pulse_cyc) ? setup_cyc : pulse_cyc;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sr_latch_write_seq_arb.sv
// Round-robin arbiter: first active req at or after ptr, circular.
// Ports: req, ptr in; one-hot grant, grant index, valid out. Combinational.
module rr_arbiter
  import sr_seq_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   idx,
  output logic            valid
);

  logic [PW-1:0] j;

  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    j     = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = PW'((int'(ptr) + k) % NREQ);
      if (!valid && req[j]) begin
        valid    = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end

endmodule

// File: rtl/sr_latch_write_seq.sv
// Sequencer driving set/clear pulses into a bank of enable-gated SR latches.
// Ports: clk, rst_n, req/op/addr in, ack/err/busy out, latch_S/R/en out, latch_Q in.
// Readback verify is built when SR_LATCH_WRITE_SEQ_VERIFY_EN is defined.
module sr_latch_write_seq
  import sr_seq_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int NLATCH    = 8,
  parameter int AW        = 3,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      op,
  input  logic [NREQ*AW-1:0]   addr,
  output logic [NREQ-1:0]      ack,
  output logic                 err,
  output logic                 busy,
  output logic [NLATCH-1:0]    latch_S,
  output logic [NLATCH-1:0]    latch_R,
  output logic [NLATCH-1:0]    latch_en,
  input  logic [NLATCH-1:0]    latch_Q
);

  localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW0 = cnt_w(SETUP_CYC, PULSE_CYC);
  // VERIFY needs to count to 2 even with short setup/pulse.
  localparam int CW  = (CW0 < 2) ? 2 : CW0;
  localparam logic [AW:0] NL = (AW+1)'(NLATCH);

  seq_state_t      state;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   g_idx;
  logic            g_op;
  logic [AW-1:0]   g_addr;

  logic [NREQ-1:0] gnt;
  logic [PW-1:0]   gi;
  logic            gv;
  logic [AW-1:0]   a_in;
  logic            op_in;
  logic [PW-1:0]   ptr_nxt;
  logic [NLATCH-1:0] a_sel;
  logic [NLATCH-1:0] g_sel;
  logic [NREQ-1:0]   g_ack;

  rr_arbiter #(
    .NREQ(NREQ),
    .PW  (PW)
  ) u_arb (
    .req  (req),
    .ptr  (ptr),
    .grant(gnt),
    .idx  (gi),
    .valid(gv)
  );

  assign a_in    = addr[gi*AW +: AW];
  assign op_in   = op[gi];
  assign ptr_nxt = PW'((int'(gi) + 1) % NREQ);
  assign a_sel   = NLATCH'(1) << a_in;
  assign g_sel   = NLATCH'(1) << g_addr;
  assign g_ack   = NREQ'(1) << g_idx;

`ifdef SR_LATCH_WRITE_SEQ_VERIFY_EN
  logic [NLATCH-1:0] q_meta;
  logic [NLATCH-1:0] q_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_meta <= '0;
      q_sync <= '0;
    end else begin
      q_meta <= latch_Q;
      q_sync <= q_meta;
    end
  end
`else
  logic unused_q;
  assign unused_q = ^{latch_Q, g_op};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      ptr      <= '0;
      g_idx    <= '0;
      g_op     <= OP_CLR;
      g_addr   <= '0;
      ack      <= '0;
      err      <= 1'b0;
      busy     <= 1'b0;
      latch_S  <= '0;
      latch_R  <= '0;
      latch_en <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gv) begin
            ptr    <= ptr_nxt;
            g_idx  <= gi;
            g_op   <= op_in;
            g_addr <= a_in;
            busy   <= 1'b1;
            cnt    <= '0;
            if ({1'b0, a_in} >= NL) begin
              state <= DONE;
              ack   <= gnt;
              err   <= 1'b1;
            end else begin
              state   <= SETUP;
              latch_S <= (op_in == OP_SET) ? a_sel : '0;
              latch_R <= (op_in == OP_SET) ? '0 : a_sel;
            end
          end
        end
        SETUP: begin
          if (cnt == CW'(SETUP_CYC - 1)) begin
            state    <= PULSE;
            cnt      <= '0;
            latch_en <= g_sel;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PULSE: begin
          if (cnt == CW'(PULSE_CYC - 1)) begin
            state    <= HOLD;
            cnt      <= '0;
            latch_en <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          latch_S <= '0;
          latch_R <= '0;
`ifdef SR_LATCH_WRITE_SEQ_VERIFY_EN
          state <= VERIFY;
          cnt   <= '0;
`else
          state <= DONE;
          ack   <= g_ack;
          err   <= 1'b0;
`endif
        end
`ifdef SR_LATCH_WRITE_SEQ_VERIFY_EN
        VERIFY: begin
          // Two cycles let the new Q settle through the synchroniser.
          if (cnt == CW'(2)) begin
            state <= DONE;
            ack   <= g_ack;
            err   <= (q_sync[g_addr] != g_op);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        DONE: begin
          state <= IDLE;
          ack   <= '0;
          err   <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          ack      <= '0;
          err      <= 1'b0;
          busy     <= 1'b0;
          latch_S  <= '0;
          latch_R  <= '0;
          latch_en <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_latch_write_seq.sv
// Directed bench for sr_latch_write_seq with a behavioural latch bank.
// Builds with or without SR_LATCH_WRITE_SEQ_VERIFY_EN.
module tb_sr_latch_write_seq;

`ifdef SR_LATCH_WRITE_SEQ_VERIFY_EN
  localparam int   ACK_CYC   = 8;
  localparam logic STUCK_ERR = 1'b1;
`else
  localparam int   ACK_CYC   = 5;
  localparam logic STUCK_ERR = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [1:0] req;
  logic [1:0] op;
  logic [5:0] addr;
  logic [1:0] ack;
  logic       err;
  logic       busy;
  logic [5:0] latch_S;
  logic [5:0] latch_R;
  logic [5:0] latch_en;
  logic [5:0] latch_Q;

  logic [5:0] mq;
  logic [5:0] stuck;
  logic       model_clr;

  int checks;
  int errors;

  sr_latch_write_seq #(
    .NREQ     (2),
    .NLATCH   (6),
    .AW       (3),
    .SETUP_CYC(1),
    .PULSE_CYC(2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .op      (op),
    .addr    (addr),
    .ack     (ack),
    .err     (err),
    .busy    (busy),
    .latch_S (latch_S),
    .latch_R (latch_R),
    .latch_en(latch_en),
    .latch_Q (latch_Q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(latch_en or latch_S or latch_R or model_clr) begin
    if (model_clr) mq = '0;
    else
      for (int i = 0; i < 6; i++) begin
        if (latch_en[i] && latch_S[i]) mq[i] = 1'b1;
        else if (latch_en[i] && latch_R[i]) mq[i] = 1'b0;
      end
  end

  assign latch_Q = mq | stuck;

  task automatic test_reset;
    rst_n = 1'b0;
    req   = '0;
    op    = '0;
    addr  = '0;
    stuck = '0;
    model_clr = 1'b1;
    repeat (2) @(negedge clk);
    model_clr = 1'b0;
    checks++;
    if ({ack, err, busy} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctl got %b want 0000", {ack, err, busy});
    end
    checks++;
    if ({latch_S, latch_R, latch_en} !== 18'b0) begin
      errors++;
      $display("FAIL reset_latch got %h want 0",
               {latch_S, latch_R, latch_en});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ack !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle busy=%b ack=%b want 0 00", busy, ack);
    end
  endtask

  task automatic test_single_set;
    logic [5:0] es, een;
    logic [1:0] ea;
    req  = 2'b01;
    op   = 2'b01;
    addr = {3'd0, 3'd3};
    for (int c = 1; c <= ACK_CYC; c++) begin
      @(negedge clk);
      es  = (c <= 4) ? 6'b001000 : 6'b0;
      een = (c == 2 || c == 3) ? 6'b001000 : 6'b0;
      ea  = (c == ACK_CYC) ? 2'b01 : 2'b00;
      checks++;
      if (latch_S !== es) begin
        errors++;
        $display("FAIL set_S c%0d got %b want %b", c, latch_S, es);
      end
      checks++;
      if (latch_en !== een) begin
        errors++;
        $display("FAIL set_en c%0d got %b want %b", c, latch_en, een);
      end
      checks++;
      if (latch_R !== 6'b0) begin
        errors++;
        $display("FAIL set_R c%0d got %b want 0", c, latch_R);
      end
      checks++;
      if (ack !== ea) begin
        errors++;
        $display("FAIL set_ack c%0d got %b want %b", c, ack, ea);
      end
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL set_busy c%0d got %b want 1", c, busy);
      end
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL set_err got %b want 0", err);
    end
    req = 2'b00;
    @(negedge clk);
    checks++;
    if (mq[3] !== 1'b1) begin
      errors++;
      $display("FAIL set_model got %b want 1", mq[3]);
    end
  endtask

  task automatic test_clear_stuck;
    logic found;
    found = 1'b0;
    stuck = 6'b100000;
    req   = 2'b01;
    op    = 2'b00;
    addr  = {3'd0, 3'd5};
    for (int c = 1; c <= 20 && !found; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checks++;
        if (latch_R !== 6'b100000 || latch_S !== 6'b0) begin
          errors++;
          $display("FAIL clr_RS got R=%b S=%b want 100000 000000",
                   latch_R, latch_S);
        end
      end
      if (ack !== 2'b00) begin
        found = 1'b1;
        checks++;
        if (ack !== 2'b01) begin
          errors++;
          $display("FAIL clr_ack got %b want 01", ack);
        end
        checks++;
        if (err !== STUCK_ERR) begin
          errors++;
          $display("FAIL clr_err got %b want %b", err, STUCK_ERR);
        end
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL clr_timeout got no ack want ack");
    end
    req   = 2'b00;
    stuck = '0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    req  = 2'b10;
    op   = 2'b10;
    addr = {3'd2, 3'd0};
    repeat (2) @(negedge clk);
    checks++;
    if (latch_en !== 6'b000100) begin
      errors++;
      $display("FAIL mid_pulse got %b want 000100", latch_en);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ack, err, busy, latch_S, latch_R, latch_en} !== 22'b0) begin
      errors++;
      $display("FAIL mid_reset got %h want 0",
               {ack, err, busy, latch_S, latch_R, latch_en});
    end
    req = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (ack !== 2'b00 || busy !== 1'b0) begin
        errors++;
        $display("FAIL mid_after c%0d ack=%b busy=%b want 00 0",
                 c, ack, busy);
      end
    end
  endtask

  task automatic test_contention;
    logic [1:0] exp_seq [4];
    logic [1:0] prev;
    int n;
    exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
    prev = 2'b00;
    n    = 0;
    req  = 2'b11;
    op   = 2'b11;
    addr = {3'd4, 3'd1};
    for (int c = 0; c < 60 && n < 4; c++) begin
      @(negedge clk);
      if (ack !== 2'b00) begin
        checks++;
        if (ack !== exp_seq[n]) begin
          errors++;
          $display("FAIL rr_order n%0d got %b want %b", n, ack, exp_seq[n]);
        end
        checks++;
        if (prev !== 2'b00) begin
          errors++;
          $display("FAIL rr_pulse n%0d prev=%b want 00", n, prev);
        end
        n++;
        if (n == 4) req = 2'b00;
      end
      prev = ack;
    end
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL rr_timeout got %0d acks want 4", n);
    end
    @(negedge clk);
    checks++;
    if (ack !== 2'b00) begin
      errors++;
      $display("FAIL rr_tail got %b want 00", ack);
    end
  endtask

  task automatic test_bad_addr;
    logic found;
    found = 1'b0;
    req   = 2'b01;
    op    = 2'b01;
    addr  = {3'd0, 3'd7};
    for (int c = 1; c <= 4 && !found; c++) begin
      @(negedge clk);
      checks++;
      if ((latch_S | latch_R | latch_en) !== 6'b0) begin
        errors++;
        $display("FAIL bad_drive c%0d got %b want 0", c,
                 latch_S | latch_R | latch_en);
      end
      if (ack !== 2'b00) begin
        found = 1'b1;
        req   = 2'b00;
        checks++;
        if (ack !== 2'b01 || err !== 1'b1) begin
          errors++;
          $display("FAIL bad_ack got ack=%b err=%b want 01 1", ack, err);
        end
        checks++;
        if (c > 2) begin
          errors++;
          $display("FAIL bad_lat got c%0d want <=2", c);
        end
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL bad_timeout got no ack want ack");
    end
    req = 2'b00;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_early_drop;
    logic found;
    found = 1'b0;
    req   = 2'b10;
    op    = 2'b00;
    addr  = {3'd4, 3'd0};
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || latch_R !== 6'b010000) begin
      errors++;
      $display("FAIL drop_setup busy=%b R=%b want 1 010000", busy, latch_R);
    end
    req = 2'b00;
    for (int c = 2; c <= 14 && !found; c++) begin
      @(negedge clk);
      if (ack !== 2'b00) begin
        found = 1'b1;
        checks++;
        if (ack !== 2'b10 || err !== 1'b0) begin
          errors++;
          $display("FAIL drop_ack got ack=%b err=%b want 10 0", ack, err);
        end
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL drop_timeout got no ack want ack");
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (ack !== 2'b00 || busy !== 1'b0) begin
        errors++;
        $display("FAIL drop_idle c%0d ack=%b busy=%b want 00 0",
                 c, ack, busy);
      end
    end
    checks++;
    if (mq[4] !== 1'b0) begin
      errors++;
      $display("FAIL drop_model got %b want 0", mq[4]);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_set();
    test_clear_stuck();
    test_reset_mid();
    test_contention();
    test_bad_addr();
    test_early_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
